dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the 32-word data memory. Port 0 is the pipeline MEM stage and port 1 is the debug/program loader. The block latches one request at a time, drives the memory's address, write-data and write-enable inputs for exactly one cycle, and returns registered read data with a per-port valid strobe. Round-robin fairness applies, plus a bounded lock so the loader can perform back-to-back bursts.

## Interface
- DEPTH, 32: memory words; legal word addresses 0..DEPTH-1
- MAX_LOCK, 8: maximum consecutive grants to a locking port while the other port waits
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-low reset
- P0_REQ_i / P1_REQ_i  input  1  access request; held until GNT seen
- P0_WE_i / P1_WE_i  input  1  1 = write, 0 = read
- P0_ADDR_i / P1_ADDR_i  input  32  word address
- P0_WDATA_i / P1_WDATA_i  input  32  write data
- P0_LOCK_i / P1_LOCK_i  input  1  keep grant on this port for the next request
- P0_GNT_o / P1_GNT_o  output  1  access in progress this cycle
- P0_RVALID_o / P1_RVALID_o  output  1  response strobe, one cycle
- RDATA_o  output  32  read data, shared, qualified by RVALID
- ERR_o  output  1  out-of-range address, qualified by RVALID
- MEM_ADDR_o  output  32  to memory ADDR_i
- MEM_WDATA_o  output  32  to memory WRT_DATA_i
- MEM_WE_o  output  1  to memory WRT_ENA_i
- MEM_RDATA_i  input  32  from memory RD_DATA_o, combinational read

## Operation
- FSM states: IDLE, GRANT, RESP.
- **IDLE:** if any REQ is high, choose a winner, latch its WE, ADDR and WDATA, and go to GRANT.
- **GRANT:**
  - The winner's GNT_o is 1. MEM_ADDR_o and MEM_WDATA_o carry the latched values.
  - MEM_WE_o = latched WE and address < DEPTH.
  - MEM_RDATA_i is captured into RDATA_o, or 0 if out of range. The out-of-range flag is captured into ERR_o.
  - Next state is always RESP.
- **RESP:** the winner's RVALID_o is 1. Arbitration is re-evaluated exactly as in IDLE: go to GRANT if any REQ is high, else IDLE.
- **Winner selection:**
  - The round-robin pointer names the preferred port and resets to port 0.
  - After each grant the pointer moves to the other port.
  - A sole requester wins regardless of the pointer.
- **Lock:**
  - If the previous winner had LOCK_i high and requests again, it wins.
  - This holds until lock_cnt reaches MAX_LOCK with the other port requesting. The other port then wins and lock_cnt clears.
  - lock_cnt increments per locked grant and clears on any switch or whenever LOCK_i is low.
- A REQ dropped before its GNT is a withdrawn request: no access is made and no response is returned.
- An out-of-range access never writes. A read returns 0 with ERR_o=1. A write also returns an RVALID strobe with ERR_o=1.
- Simultaneous REQ from both ports with pointer=1: port 1 wins and port 0 is served in the next GRANT.

## Timing
- Request seen in cycle N (IDLE or RESP): GNT_o in N+1, memory write at the end of N+1, RVALID_o in N+2.
- Peak throughput is one access per 2 cycles. GRANT and RESP alternate under continuous requests.
- Every output is a register or a decode of registers, with no combinational path from REQ to GNT.
- The requester may change or drop its signals in the cycle after GNT.
- **Reset (rst_i=0, asynchronous):**
  - State goes to IDLE, pointer to port 0, lock_cnt to 0.
  - Every output goes to 0, including all GNT, RVALID, MEM_WE_o, MEM_ADDR_o, MEM_WDATA_o, RDATA_o and ERR_o.
  - Reset asserted during GRANT suppresses the write at the following edge, and the in-flight response is discarded.
- Reset release: the first grant is possible in the 2nd cycle after deassertion.

## Structure
- Shared package `dmem_pkg`:
  - state encoding for IDLE, GRANT and RESP
  - DEPTH default
  - port index constants
- One natural sub-module, `rr_lock_sel`: the pointer, lock counter and winner selection. It takes 2 REQ bits, 2 LOCK bits and an advance strobe, and outputs the one-hot winner.
- The FSM, latches and response registers stay in the top module.

## Test plan
- Port 0 writes 0xDEADBEEF to address 5, then reads address 5 → GNT at N+1, MEM_WE_o=1 for one cycle; the read returns RDATA_o=0xDEADBEEF with P0_RVALID_o at N+2, ERR_o=0.
- Both ports request continuously without lock from reset → grants alternate 0,1,0,1, each port served every 4 cycles.
- Port 1 holds LOCK_i with 12 back-to-back writes while port 0 requests → 8 consecutive port-1 grants, then one port-0 grant, then port 1 resumes.
- Port 0 writes 0x1 to address 40 (DEPTH=32) → MEM_WE_o stays 0, RVALID with ERR_o=1; a later read of address 8 is unchanged.
- rst_i asserted in a GRANT cycle of a write of 0xA5A5A5A5 to address 3 → all outputs 0 immediately, address 3 retains its old value, first GNT occurs 2 cycles after release.
- Port 1 raises REQ for one cycle while port 0 holds GRANT, then drops it before winning → no P1_GNT_o and no P1_RVALID_o.

Source files
------------

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared constants and FSM encoding for the data memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam int unsigned DEPTH_DEF    = 32;
  localparam int unsigned MAX_LOCK_DEF = 8;

  localparam int unsigned PORT0 = 0;
  localparam int unsigned PORT1 = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if : requester-side bus of the two-port data memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if;

  logic        P0_REQ_i;
  logic        P0_WE_i;
  logic [31:0] P0_ADDR_i;
  logic [31:0] P0_WDATA_i;
  logic        P0_LOCK_i;
  logic        P0_GNT_o;
  logic        P0_RVALID_o;

  logic        P1_REQ_i;
  logic        P1_WE_i;
  logic [31:0] P1_ADDR_i;
  logic [31:0] P1_WDATA_i;
  logic        P1_LOCK_i;
  logic        P1_GNT_o;
  logic        P1_RVALID_o;

  logic [31:0] RDATA_o;
  logic        ERR_o;

  modport slave (
    input  P0_REQ_i, P0_WE_i, P0_ADDR_i, P0_WDATA_i, P0_LOCK_i,
    input  P1_REQ_i, P1_WE_i, P1_ADDR_i, P1_WDATA_i, P1_LOCK_i,
    output P0_GNT_o, P0_RVALID_o, P1_GNT_o, P1_RVALID_o, RDATA_o, ERR_o
  );

  modport master (
    output P0_REQ_i, P0_WE_i, P0_ADDR_i, P0_WDATA_i, P0_LOCK_i,
    output P1_REQ_i, P1_WE_i, P1_ADDR_i, P1_WDATA_i, P1_LOCK_i,
    input  P0_GNT_o, P0_RVALID_o, P1_GNT_o, P1_RVALID_o, RDATA_o, ERR_o
  );

endinterface

`default_nettype wire

// File: rtl/rr_lock_sel.sv
// ---------------------------------------------------------------------------
// rr_lock_sel : round-robin winner select with a bounded per-port grant lock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_lock_sel
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic       adv_i,
  output logic [1:0] win_o
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  logic          ptr_q;
  logic          last_q;
  logic          last_lock_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          hold;
  logic          win_idx;

  always_comb begin
    // A locked owner keeps the port until its budget is spent and the other side is waiting.
    hold    = last_lock_q && req_i[last_q] &&
              !((cnt_q >= CW'(MAX_LOCK)) && req_i[~last_q]);
    win_idx = 1'b0;
    if (hold)
      win_idx = last_q;
    else if (req_i == 2'b11)
      win_idx = ptr_q;
    else
      win_idx = ~req_i[0];
    win_o = (|req_i) ? (2'b01 << win_idx) : 2'b00;

    cnt_d = '0;
    if (lock_i[win_idx]) begin
      if (win_idx == last_q && last_lock_q)
        cnt_d = (cnt_q >= CW'(MAX_LOCK)) ? cnt_q : cnt_q + CW'(1);
      else
        cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q       <= 1'b0;
      last_q      <= 1'b0;
      last_lock_q <= 1'b0;
      cnt_q       <= '0;
    end else if (adv_i && (|req_i)) begin
      ptr_q       <= ~win_idx;
      last_q      <= win_idx;
      last_lock_q <= lock_i[win_idx];
      cnt_q       <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter : two-port arbiter and one-access sequencer for the 32-word data memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus,
  output logic [31:0]    MEM_ADDR_o,
  output logic [31:0]    MEM_WDATA_o,
  output logic           MEM_WE_o,
  input  logic [31:0]    MEM_RDATA_i
);

  state_t      state_q;
  logic [1:0]  gnt_q;
  logic [1:0]  rvalid_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        oor_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  req;
  logic [1:0]  lock;
  logic [1:0]  win;
  logic        arb;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_oor;

  assign req       = {bus.P1_REQ_i, bus.P0_REQ_i};
  assign lock      = {bus.P1_LOCK_i, bus.P0_LOCK_i};
  assign arb       = (state_q != S_GRANT);
  assign sel_we    = win[PORT1] ? bus.P1_WE_i    : bus.P0_WE_i;
  assign sel_addr  = win[PORT1] ? bus.P1_ADDR_i  : bus.P0_ADDR_i;
  assign sel_wdata = win[PORT1] ? bus.P1_WDATA_i : bus.P0_WDATA_i;
  assign sel_oor   = (sel_addr >= DEPTH);

  rr_lock_sel #(
    .MAX_LOCK (MAX_LOCK)
  ) u_sel (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req),
    .lock_i (lock),
    .adv_i  (arb),
    .win_o  (win)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_GRANT: begin
          rdata_q  <= oor_q ? 32'd0 : MEM_RDATA_i;
          err_q    <= oor_q;
          rvalid_q <= gnt_q;
          gnt_q    <= '0;
          we_q     <= 1'b0;
          state_q  <= S_RESP;
        end
        S_IDLE, S_RESP: begin
          rvalid_q <= '0;
          if (|req) begin
            gnt_q   <= win;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we && !sel_oor;
            oor_q   <= sel_oor;
            state_q <= S_GRANT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.P0_GNT_o    = gnt_q[PORT0];
  assign bus.P1_GNT_o    = gnt_q[PORT1];
  assign bus.P0_RVALID_o = rvalid_q[PORT0];
  assign bus.P1_RVALID_o = rvalid_q[PORT1];
  assign bus.RDATA_o     = rdata_q;
  assign bus.ERR_o       = err_q;
  assign MEM_ADDR_o      = addr_q;
  assign MEM_WDATA_o     = wdata_q;
  assign MEM_WE_o        = we_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed bench for dmem_arbiter with a 32-word memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_load;
  logic [31:0] mem [32];

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bus         (bus),
    .MEM_ADDR_o  (mem_addr),
    .MEM_WDATA_o (mem_wdata),
    .MEM_WE_o    (mem_we),
    .MEM_RDATA_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory preload: word k holds 0x1000_0000 + k.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 32; k++) mem[k] <= 32'h1000_0000 + 32'(k);
    end else if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[4:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic lk,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.P0_REQ_i = req; bus.P0_WE_i = we; bus.P0_LOCK_i = lk;
      bus.P0_ADDR_i = addr; bus.P0_WDATA_i = wdata;
    end else begin
      bus.P1_REQ_i = req; bus.P1_WE_i = we; bus.P1_LOCK_i = lk;
      bus.P1_ADDR_i = addr; bus.P1_WDATA_i = wdata;
    end
  endtask

  function automatic logic [1:0] gnt2();
    return {bus.P1_GNT_o, bus.P0_GNT_o};
  endfunction

  function automatic logic [1:0] rv2();
    return {bus.P1_RVALID_o, bus.P0_RVALID_o};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, gnt2(), rv2(), mem_we, bus.ERR_o}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata"}, bus.RDATA_o, 32'd0);
  endtask

  // Single isolated access from IDLE: grant cycle, response cycle, back to IDLE.
  task automatic xfer(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_we, input logic [31:0] exp_rd, input logic exp_err);
    logic [1:0] onehot;
    onehot = (p == 0) ? 2'b01 : 2'b10;
    set_port(p, 1'b1, we, 1'b0, addr, wdata);
    tick();
    chk("xf_gnt", {30'd0, gnt2()}, {30'd0, onehot});
    chk("xf_we", {31'd0, mem_we}, {31'd0, exp_we});
    chk("xf_addr", mem_addr, addr);
    set_port(p, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("xf_rvalid", {30'd0, rv2()}, {30'd0, onehot});
    chk("xf_err", {31'd0, bus.ERR_o}, {31'd0, exp_err});
    if (!we) chk("xf_rdata", bus.RDATA_o, exp_rd);
    tick();
  endtask

  logic [1:0] exp_g [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] exp_v [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  int         exp_ord [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  int         got_ord [$];

  initial begin
    int         p1_done;
    logic [1:0] seen;

    rst_n    = 1'b0;
    mem_load = 1'b1;
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    mem_load = 1'b0;
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Round-robin from reset: both ports reading continuously, no lock.
    set_port(0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    set_port(1, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_gnt", {30'd0, gnt2()}, {30'd0, exp_g[k]});
      chk("rr_rvalid", {30'd0, rv2()}, {30'd0, exp_v[k]});
      if (exp_v[k] != 2'b00)
        chk("rr_rdata", bus.RDATA_o, (exp_v[k] == 2'b01) ? 32'h1000_0001 : 32'h1000_0002);
      if (k == 6) begin
        set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    tick();

    // Port 1 locked burst of 12 writes; port 0 joins after the first grant.
    p1_done = 0;
    set_port(1, 1'b1, 1'b1, 1'b1, 32'd10, 32'h100);
    for (int c = 0; c < 80 && got_ord.size() < 13; c++) begin
      tick();
      if (bus.P1_GNT_o) begin
        got_ord.push_back(1);
        p1_done++;
        if (p1_done == 1) set_port(0, 1'b1, 1'b0, 1'b0, 32'd20, 32'd0);
        if (p1_done < 12)
          set_port(1, 1'b1, 1'b1, 1'b1, 32'd10 + 32'(p1_done), 32'h100 + 32'(p1_done));
        else
          set_port(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      if (bus.P0_GNT_o) begin
        got_ord.push_back(0);
        set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    chk("lock_ngrants", 32'(got_ord.size()), 32'd13);
    for (int i = 0; i < 13; i++)
      chk("lock_order", (i < got_ord.size()) ? 32'(got_ord[i]) : 32'd99, 32'(exp_ord[i]));
    tick();
    tick();
    for (int i = 0; i < 12; i++)
      chk("lock_wr", mem[10 + i], 32'h100 + 32'(i));

    // Back-to-back write then read on port 0.
    set_port(0, 1'b1, 1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
    tick();
    chk("wr_gnt", {30'd0, gnt2()}, 32'd1);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_addr", mem_addr, 32'd5);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    set_port(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    tick();
    chk("wr_rvalid", {30'd0, rv2()}, 32'd1);
    chk("wr_ctl", {29'd0, gnt2(), mem_we}, 32'd0);
    chk("wr_err", {31'd0, bus.ERR_o}, 32'd0);
    chk("wr_mem", mem[5], 32'hDEAD_BEEF);
    tick();
    chk("rd_gnt", {30'd0, gnt2()}, 32'd1);
    chk("rd_we", {31'd0, mem_we}, 32'd0);
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("rd_rvalid", {30'd0, rv2()}, 32'd1);
    chk("rd_rdata", bus.RDATA_o, 32'hDEAD_BEEF);
    chk("rd_err", {31'd0, bus.ERR_o}, 32'd0);
    tick();
    chk("rd_idle", {30'd0, rv2()}, 32'd0);

    // Address range boundaries.
    xfer(0, 1'b1, 32'd40, 32'd1, 1'b0, 32'd0, 1'b1);
    xfer(0, 1'b0, 32'd8, 32'd0, 1'b0, 32'h1000_0008, 1'b0);
    xfer(1, 1'b0, 32'd32, 32'd0, 1'b0, 32'd0, 1'b1);
    xfer(1, 1'b1, 32'd31, 32'h31, 1'b1, 32'd0, 1'b0);
    xfer(1, 1'b0, 32'd31, 32'd0, 1'b0, 32'h31, 1'b0);

    // Port 1 pulses REQ only during port 0's grant cycle.
    set_port(0, 1'b1, 1'b0, 1'b0, 32'd4, 32'd0);
    tick();
    chk("wd_p0_gnt", {30'd0, gnt2()}, 32'd1);
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b1, 1'b1, 1'b0, 32'd6, 32'h77);
    tick();
    chk("wd_p0_rvalid", {30'd0, rv2()}, 32'd1);
    chk("wd_p0_rdata", bus.RDATA_o, 32'h1000_0004);
    set_port(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    seen = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | {bus.P1_GNT_o, bus.P1_RVALID_o};
    end
    chk("wd_p1_none", {30'd0, seen}, 32'd0);
    chk("wd_mem", mem[6], 32'h1000_0006);

    // Reset asserted mid-grant of a write.
    set_port(0, 1'b1, 1'b1, 1'b0, 32'd3, 32'hA5A5_A5A5);
    tick();
    chk("rg_gnt", {30'd0, gnt2()}, 32'd1);
    chk("rg_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rg_async");
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("rg_mem", mem[3], 32'h1000_0003);
    chk("rg_rvalid", {30'd0, rv2()}, 32'd0);
    set_port(0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
    tick();
    chk("rg_held", {30'd0, gnt2()}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rg_first_gnt", {30'd0, gnt2()}, 32'd1);
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("rg_rvalid2", {30'd0, rv2()}, 32'd1);
    chk("rg_rdata", bus.RDATA_o, 32'h1000_0003);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
